// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer: a valid/ready input stream is steered
// to one of N_OUT independently drained output registers, select locked per packet.
//
// state  | meaning
// IDLE   | next accepted beat is the first of a packet; in_sel picks the target
// LOCKED | mid-packet, beats go to lock_sel regardless of in_sel
// DROP   | mid-packet with an invalid select, beats are accepted and discarded
module stream_demux #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_last,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic                    err_sel
);

  typedef enum logic [1:0] {IDLE, LOCKED, DROP} state_t;

  localparam logic [SEL_W:0] NOUT_V = (SEL_W+1)'(N_OUT);

  state_t           state;
  logic [SEL_W-1:0] lock_sel;
  logic [SEL_W-1:0] tgt;
  logic             sel_ok;
  logic             tgt_busy;
  logic             accept;
  logic             fwd;

  assign sel_ok = ({1'b0, in_sel} < NOUT_V);
  assign tgt    = (state == LOCKED) ? lock_sel : in_sel;

  // Target register is busy only if it holds a beat its consumer is not taking now.
  always_comb begin
    tgt_busy = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (tgt == SEL_W'(k)) tgt_busy = out_valid[k] & ~out_ready[k];
    end
  end

  assign in_ready = ~rst & ((state == DROP) | ((state == IDLE) & ~sel_ok) | ~tgt_busy);
  assign accept   = in_valid & in_ready;
  assign fwd      = accept & ((state == LOCKED) | ((state == IDLE) & sel_ok));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lock_sel <= '0;
      err_sel  <= 1'b0;
    end else begin
      err_sel <= accept & (state == IDLE) & ~sel_ok;
      case (state)
        IDLE: begin
          if (accept && !in_last) begin
            if (sel_ok) begin
              state    <= LOCKED;
              lock_sel <= in_sel;
            end else begin
              state <= DROP;
            end
          end
        end
        LOCKED:  if (accept && in_last) state <= IDLE;
        DROP:    if (accept && in_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A load in the same cycle as a drain replaces the beat, keeping 1 beat/clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_last  <= '0;
      out_valid <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (fwd && (tgt == SEL_W'(k))) begin
          out_data[k*DATA_W +: DATA_W] <= in_data;
          out_last[k]                  <= in_last;
          out_valid[k]                 <= 1'b1;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: a 4-port instance for routing/backpressure
// and a 3-port instance for invalid-select drops.
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_last;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        err_sel;

  logic [7:0]  i3_data;
  logic [1:0]  i3_sel;
  logic        i3_last;
  logic        i3_valid;
  logic        i3_ready;
  logic [23:0] o3_data;
  logic [2:0]  o3_last;
  logic [2:0]  o3_valid;
  logic [2:0]  o3_ready;
  logic        err3;

  int total = 0;
  int bad   = 0;
  int err3_cnt;
  logic [2:0] o3_seen;
  logic [8:0] exp_q[4][$];

  always #5 clk = ~clk;

  stream_demux #(.DATA_W(8), .N_OUT(4), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .err_sel(err_sel));

  stream_demux #(.DATA_W(8), .N_OUT(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .in_data(i3_data), .in_sel(i3_sel), .in_last(i3_last),
    .in_valid(i3_valid), .in_ready(i3_ready), .out_data(o3_data), .out_last(o3_last),
    .out_valid(o3_valid), .out_ready(o3_ready), .err_sel(err3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Consumer side: a handshake seen mid-cycle completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) chk($sformatf("unexpected_p%0d", k), 32'(out_valid[k]), 0);
          else chk($sformatf("sb_p%0d", k), {23'd0, out_last[k], out_data[k*8 +: 8]},
                   {23'd0, exp_q[k].pop_front()});
        end
      end
      if (err3) err3_cnt++;
      o3_seen = o3_seen | o3_valid;
    end
  end

  // port < 0 means the beat is expected to be dropped
  task automatic send(input logic [7:0] d, input logic [1:0] s, input logic l, input int port);
    logic got;
    in_data = d; in_sel = s; in_last = l; in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    chk("accept", 32'(got), 1);
    if (port >= 0) exp_q[port].push_back({l, d});
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (port >= 0) begin
      chk("lat_valid", 32'(out_valid[port]), 1);
      chk("lat_data", 32'(out_data[port*8 +: 8]), 32'(d));
      chk("lat_last", 32'(out_last[port]), 32'(l));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b1; in_data = 8'hEE; in_sel = 2'd0; in_last = 1'b1; out_ready = 4'hF;
    i3_valid = 1'b1; i3_data = 8'hEE; i3_sel = 2'd0; i3_last = 1'b1; o3_ready = 3'h7;
    err3_cnt = 0; o3_seen = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err_sel", 32'(err_sel), 0);
    chk("rst3_in_ready", 32'(i3_ready), 0);
    in_valid = 1'b0; i3_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // locked select: in_sel changes mid-packet are ignored
    send(8'h11, 2'd2, 1'b0, 2);
    send(8'h22, 2'd0, 1'b0, 2);
    send(8'h33, 2'd0, 1'b1, 2);
    @(posedge clk); #1;
    chk("p0_untouched", 32'(out_valid[0]), 0);

    // backpressure on port 1
    out_ready[1] = 1'b0;
    send(8'hA0, 2'd1, 1'b0, 1);
    in_data = 8'hA1; in_sel = 2'd1; in_last = 1'b1; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_hold", 32'(out_data[15:8]), 32'h A0);
    end
    @(posedge clk); #1;
    out_ready[1] = 1'b1;
    send(8'hA1, 2'd1, 1'b1, 1);

    // invalid select on the 3-port instance
    err3_cnt = 0; o3_seen = '0;
    i3_data = 8'h90; i3_sel = 2'd3; i3_last = 1'b0; i3_valid = 1'b1;
    @(negedge clk);
    chk("drop_rdy0", 32'(i3_ready), 1);
    @(posedge clk); #1;
    i3_data = 8'h91; i3_last = 1'b1; i3_sel = 2'd1;
    @(negedge clk);
    chk("drop_rdy1", 32'(i3_ready), 1);
    @(posedge clk); #1;
    i3_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("err_pulses", 32'(err3_cnt), 1);
    chk("drop_no_valid", 32'(o3_seen), 0);
    i3_data = 8'h77; i3_sel = 2'd0; i3_last = 1'b1; i3_valid = 1'b1;
    @(negedge clk);
    chk("after_drop_rdy", 32'(i3_ready), 1);
    @(posedge clk); #1;
    i3_valid = 1'b0;
    chk("after_drop_valid", 32'(o3_valid), 1);
    chk("after_drop_data", 32'(o3_data[7:0]), 32'h77);
    chk("after_drop_err", 32'(err3), 0);

    // stalled port 0 does not block a packet to port 3
    out_ready[0] = 1'b0;
    send(8'h55, 2'd0, 1'b1, 0);
    send(8'h66, 2'd3, 1'b1, 3);
    chk("p0_still_held", 32'(out_valid[0]), 1);
    chk("p0_held_data", 32'(out_data[7:0]), 32'h55);
    out_ready[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // async reset mid-packet with a beat held on port 1
    out_ready[1] = 1'b0;
    send(8'h61, 2'd1, 1'b0, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_ready", 32'(in_ready), 0);
    exp_q[1].delete();
    #1 rst = 1'b0;
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    send(8'h70, 2'd2, 1'b1, 2);
    chk("midrst_p1_idle", 32'(out_valid[1]), 0);

    out_ready = 4'hF;
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) chk($sformatf("drained_p%0d", k), exp_q[k].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
